// File: rtl/mmio_responder.sv
// mmio_responder
//
// Memory-mapped responder on the core's data port.  Decodes the
// address, write data and write strobe driven by the memory stage
// and answers reads combinationally in the same cycle.
//
// Address map (addr_i[1:0] ignored everywhere):
//   0x0000_0000 .. RAM_WORDS*4-1 : data RAM (async read, sync write)
//   0x1000_0000 CMD    : write pushes a word into the command FIFO, reads 0
//   0x1000_0004 STATUS : {16'b0, count[7:0], 6'b0, full, empty}, read-only
//   0x1000_0008 CYCLES : free-running cycle counter, any write clears it
//   0x1000_000C DROPS  : pushes rejected while full (saturating), write clears
//   anything else      : reads 0, writes have no effect
//
// Ports:
//   clk_i        system clock, rising-edge
//   reset_i      asynchronous active-low reset
//   addr_i       byte address from the memory stage
//   wr_data_i    write data from the core
//   wr_en_i      write strobe, commits at the rising edge
//   rd_data_o    combinational read data for addr_i
//   cmd_data_o   command FIFO head word (first-word fall-through)
//   cmd_valid_o  command FIFO non-empty
//   cmd_ready_i  GPU front end accepts cmd_data_o this cycle

module mmio_responder #(
    parameter int RAM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wr_data_i,
    input  logic        wr_en_i,
    output logic [31:0] rd_data_o,
    output logic [31:0] cmd_data_o,
    output logic        cmd_valid_o,
    input  logic        cmd_ready_i
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [31:0] RAM_BYTES   = 32'(RAM_WORDS * 4);
    localparam logic [31:0] CMD_ADDR    = 32'h1000_0000;
    localparam logic [31:0] STATUS_ADDR = 32'h1000_0004;
    localparam logic [31:0] CYCLES_ADDR = 32'h1000_0008;
    localparam logic [31:0] DROPS_ADDR  = 32'h1000_000C;

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [31:0]       word_addr;
    logic [RAM_AW-1:0] ram_index;
    logic              sel_ram;
    logic              sel_cmd;
    logic              sel_status;
    logic              sel_cycles;
    logic              sel_drops;

    // Byte lanes are ignored, so the register decode works on the
    // word-aligned address.  The RAM range check can use the raw address
    // because the RAM size is a whole number of words.
    assign word_addr  = {addr_i[31:2], 2'b00};
    assign ram_index  = addr_i[RAM_AW+1:2];
    assign sel_ram    = (addr_i < RAM_BYTES);
    assign sel_cmd    = (word_addr == CMD_ADDR);
    assign sel_status = (word_addr == STATUS_ADDR);
    assign sel_cycles = (word_addr == CYCLES_ADDR);
    assign sel_drops  = (word_addr == DROPS_ADDR);

    // ------------------------------------------------------------------
    // Data RAM: contents are deliberately not reset
    // ------------------------------------------------------------------
    logic [31:0] ram [RAM_WORDS];

    always_ff @(posedge clk_i) begin
        if (wr_en_i && sel_ram) begin
            ram[ram_index] <= wr_data_i;
        end
    end

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [31:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push_req;
    logic             push;
    logic             pop;
    logic             drop;

    assign fifo_full  = (count == FULL_COUNT);
    assign fifo_empty = (count == '0);
    assign push_req   = wr_en_i && sel_cmd;
    assign pop        = !fifo_empty && cmd_ready_i;

    // A push into a full FIFO is still accepted when a pop frees a slot
    // on the same edge.  In that case wr_ptr equals rd_ptr, so the new
    // word overwrites the slot being popped, which becomes the tail once
    // rd_ptr advances -- ordering stays correct.
    assign push = push_req && (!fifo_full || pop);
    assign drop = push_req && fifo_full && !pop;

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // The head slot is only rewritten while empty or while being popped,
    // so the word stays stable whenever the consumer stalls.
    assign cmd_data_o  = fifo_mem[rd_ptr];
    assign cmd_valid_o = !fifo_empty;

    // ------------------------------------------------------------------
    // Cycle counter: a write clears it and wins over the increment
    // ------------------------------------------------------------------
    logic [31:0] cycles;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cycles <= '0;
        end else if (wr_en_i && sel_cycles) begin
            cycles <= '0;
        end else begin
            cycles <= cycles + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Drop counter: saturates, and a clear wins over a coincident drop
    // ------------------------------------------------------------------
    logic [31:0] drops;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            drops <= '0;
        end else if (wr_en_i && sel_drops) begin
            drops <= '0;
        end else if (drop && (drops != 32'hFFFF_FFFF)) begin
            drops <= drops + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Status word: the occupancy field is 8 bits wide regardless of depth
    // ------------------------------------------------------------------
    logic [7:0]  count_byte;
    logic [31:0] status_word;

    if (CNT_W >= 8) begin : g_count_trunc
        assign count_byte = count[7:0];
    end else begin : g_count_pad
        assign count_byte = {{(8 - CNT_W){1'b0}}, count};
    end

    assign status_word = {16'b0, count_byte, 6'b0, fifo_full, fifo_empty};

    // ------------------------------------------------------------------
    // Read mux: reflects pre-edge state, zero for unmapped addresses
    // ------------------------------------------------------------------
    always_comb begin
        rd_data_o = '0;
        if (sel_ram) begin
            rd_data_o = ram[ram_index];
        end else if (sel_status) begin
            rd_data_o = status_word;
        end else if (sel_cycles) begin
            rd_data_o = cycles;
        end else if (sel_drops) begin
            rd_data_o = drops;
        end
    end

endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder
//
// Scoreboard bench for mmio_responder.  A queue-based reference model
// updates on every clock edge; read expectations are queued when a read
// is issued and popped by a monitor on the falling edge, while the
// command port is compared against the model's FIFO head whenever the
// DUT may present a word.

module tb_mmio_responder;

    localparam int RAM_WORDS  = 1024;
    localparam int FIFO_DEPTH = 16;

    localparam logic [31:0] RAM_BYTES   = 32'(RAM_WORDS * 4);
    localparam logic [31:0] CMD_ADDR    = 32'h1000_0000;
    localparam logic [31:0] STATUS_ADDR = 32'h1000_0004;
    localparam logic [31:0] CYCLES_ADDR = 32'h1000_0008;
    localparam logic [31:0] DROPS_ADDR  = 32'h1000_000C;

    logic        clk_i       = 1'b0;
    logic        reset_i     = 1'b0;
    logic [31:0] addr_i      = '0;
    logic [31:0] wr_data_i   = '0;
    logic        wr_en_i     = 1'b0;
    logic        cmd_ready_i = 1'b0;
    logic [31:0] rd_data_o;
    logic [31:0] cmd_data_o;
    logic        cmd_valid_o;

    mmio_responder #(
        .RAM_WORDS (RAM_WORDS),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .addr_i     (addr_i),
        .wr_data_i  (wr_data_i),
        .wr_en_i    (wr_en_i),
        .rd_data_o  (rd_data_o),
        .cmd_data_o (cmd_data_o),
        .cmd_valid_o(cmd_valid_o),
        .cmd_ready_i(cmd_ready_i)
    );

    always #5 clk_i = ~clk_i;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] m_fifo [$];
    logic [31:0] m_ram [int];
    logic [31:0] m_cycles = '0;
    logic [31:0] m_drops  = '0;

    // Read scoreboard
    logic [31:0] rd_exp_q [$];
    logic [31:0] rd_addr_q [$];
    logic        rd_chk = 1'b0;
    logic [31:0] mon_exp;
    logic [31:0] mon_addr;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Model of one clock edge, straight from the register-map rules
    task automatic model_edge();
        logic [31:0] w;
        logic [31:0] dummy;
        bit          drop;
        w    = {addr_i[31:2], 2'b00};
        drop = 1'b0;
        if (m_fifo.size() != 0 && cmd_ready_i) begin
            dummy = m_fifo.pop_front();
        end
        if (wr_en_i && w == CMD_ADDR) begin
            if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(wr_data_i);
            else drop = 1'b1;
        end
        if (wr_en_i && w == CYCLES_ADDR) m_cycles = '0;
        else m_cycles = m_cycles + 32'd1;
        if (wr_en_i && w == DROPS_ADDR) m_drops = '0;
        else if (drop && m_drops != 32'hFFFF_FFFF) m_drops = m_drops + 32'd1;
        if (wr_en_i && addr_i < RAM_BYTES) m_ram[int'(addr_i >> 2)] = wr_data_i;
    endtask

    always @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            m_fifo.delete();
            m_cycles = '0;
            m_drops  = '0;
        end else begin
            model_edge();
        end
    end

    function automatic bit model_readable(input logic [31:0] a);
        return !(a < RAM_BYTES) || m_ram.exists(int'(a >> 2));
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] w;
        int          n;
        w = {a[31:2], 2'b00};
        n = m_fifo.size();
        if (a < RAM_BYTES) return m_ram[int'(a >> 2)];
        if (w == STATUS_ADDR) return {16'b0, 8'(n), 6'b0, n == FIFO_DEPTH, n == 0};
        if (w == CYCLES_ADDR) return m_cycles;
        if (w == DROPS_ADDR) return m_drops;
        return '0;
    endfunction

    // Drive one cycle of inputs just after the rising edge; queue the
    // expected read value when requested and predictable.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d,
                                 input logic we, input logic rdy, input bit chk);
        @(posedge clk_i);
        #1;
        addr_i      = a;
        wr_data_i   = d;
        wr_en_i     = we;
        cmd_ready_i = rdy;
        rd_chk      = 1'b0;
        if (chk && model_readable(a)) begin
            rd_exp_q.push_back(model_read(a));
            rd_addr_q.push_back(a);
            rd_chk = 1'b1;
        end
    endtask

    // Monitor: compares read data and the command port on the falling edge
    always @(negedge clk_i) begin
        if (rd_chk && rd_exp_q.size() > 0) begin
            mon_exp  = rd_exp_q.pop_front();
            mon_addr = rd_addr_q.pop_front();
            checkOutput($sformatf("rd_data@%h", mon_addr), rd_data_o, mon_exp);
        end
        checkOutput("cmd_valid", {31'b0, cmd_valid_o}, {31'b0, m_fifo.size() != 0});
        if (m_fifo.size() != 0) begin
            checkOutput("cmd_data", cmd_data_o, m_fifo[0]);
        end
    end

    initial begin
        logic [31:0] a;
        logic        we;
        int          r;

        // Reset state
        reset_i = 1'b0;
        addr_i  = STATUS_ADDR;
        #3;
        checkOutput("reset_status", rd_data_o, 32'h0000_0001);
        checkOutput("reset_valid", {31'b0, cmd_valid_o}, 32'd0);
        #9;
        reset_i = 1'b1;
        repeat (4) applyStimulus(STATUS_ADDR, '0, 1'b0, 1'b0, 1'b0);
        applyStimulus(CYCLES_ADDR, '0, 1'b0, 1'b0, 1'b1);

        // RAM write/readback and unmapped read
        applyStimulus(32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
        applyStimulus(32'h0000_0010, '0, 1'b0, 1'b0, 1'b1);
        applyStimulus(32'h0000_0013, '0, 1'b0, 1'b0, 1'b1);
        applyStimulus(32'h2000_0000, '0, 1'b0, 1'b0, 1'b1);
        applyStimulus(CMD_ADDR, '0, 1'b0, 1'b0, 1'b1);

        // Fill, overflow, drain
        for (int i = 1; i <= 16; i++) applyStimulus(CMD_ADDR, 32'(i), 1'b1, 1'b0, 1'b0);
        applyStimulus(STATUS_ADDR, '0, 1'b0, 1'b0, 1'b1);
        applyStimulus(CMD_ADDR, 32'd17, 1'b1, 1'b0, 1'b0);
        applyStimulus(DROPS_ADDR, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 18; i++) applyStimulus(STATUS_ADDR, '0, 1'b0, 1'b1, 1'b1);

        // Push into a full FIFO while popping
        for (int i = 0; i < 16; i++) applyStimulus(CMD_ADDR, 32'h200 + 32'(i), 1'b1, 1'b0, 1'b0);
        applyStimulus(CMD_ADDR, 32'h0000_00AA, 1'b1, 1'b1, 1'b0);
        applyStimulus(STATUS_ADDR, '0, 1'b0, 1'b0, 1'b1);
        applyStimulus(DROPS_ADDR, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 18; i++) applyStimulus(STATUS_ADDR, '0, 1'b0, 1'b1, 1'b0);

        // Pointer wrap-around: push, then pop on the following cycle
        for (int i = 0; i < 40; i++) begin
            applyStimulus(CMD_ADDR, 32'h300 + 32'(i), 1'b1, 1'b0, 1'b0);
            applyStimulus(STATUS_ADDR, '0, 1'b0, 1'b1, 1'b1);
        end
        applyStimulus(DROPS_ADDR, '0, 1'b0, 1'b0, 1'b1);

        // Randomised traffic over the whole map
        for (int i = 0; i < 500; i++) begin
            r  = int'($urandom_range(0, 99));
            we = 1'b0;
            if (r < 30) begin
                a  = CMD_ADDR | 32'($urandom_range(0, 3));
                we = ($urandom_range(0, 9) < 7);
            end else if (r < 45) begin
                a  = STATUS_ADDR;
                we = $urandom_range(0, 1) == 1;
            end else if (r < 55) begin
                a  = CYCLES_ADDR;
                we = $urandom_range(0, 3) == 0;
            end else if (r < 62) begin
                a  = DROPS_ADDR;
                we = $urandom_range(0, 3) == 0;
            end else if (r < 85) begin
                a  = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
                we = $urandom_range(0, 1) == 1;
            end else begin
                case ($urandom_range(0, 3))
                    0:       a = 32'h1000_0010;
                    1:       a = 32'h2000_0000;
                    2:       a = RAM_BYTES;
                    default: a = 32'hFFFF_FFFC;
                endcase
                we = $urandom_range(0, 1) == 1;
            end
            applyStimulus(a, $urandom, we, $urandom_range(0, 2) == 0, 1'b1);
        end

        // Reset with words queued
        for (int i = 0; i < 5; i++) applyStimulus(CMD_ADDR, 32'h400 + 32'(i), 1'b1, 1'b0, 1'b0);
        applyStimulus(CYCLES_ADDR, '0, 1'b0, 1'b0, 1'b0);
        #2;
        reset_i = 1'b0;
        #1;
        checkOutput("reset_flush_valid", {31'b0, cmd_valid_o}, 32'd0);
        @(negedge clk_i);
        #2;
        reset_i = 1'b1;
        #1;
        checkOutput("post_reset_cycles", rd_data_o, 32'd0);
        addr_i = STATUS_ADDR;
        #1;
        checkOutput("post_reset_status", rd_data_o, 32'h0000_0001);
        repeat (3) applyStimulus(CYCLES_ADDR, '0, 1'b0, 1'b1, 1'b1);

        @(posedge clk_i);
        #1;
        rd_chk = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
